// File: rtl/checkbits_seq_monitor.sv
// checkbits_seq_monitor
//
// Watches a 16-bit status word driven by firmware and checks that it steps
// through an expected sequence of values. The sequence is framed by
// START_MARK and END_MARK. A value only counts once it has held steady long
// enough to be "settled", so short glitches are never seen.
//
// Ports
//   clock      : single clock, rising edge
//   resetb     : synchronous active-low reset (table contents are kept)
//   checkbits  : observed status word
//   exp_we     : expected-table write strobe (honoured only while idle)
//   exp_addr   : expected-table write address
//   exp_data   : expected-table write data
//   exp_count  : number of valid table entries, sampled on start
//   start      : one-cycle pulse that arms the monitor
//   busy       : run in progress
//   match_stb  : one-cycle pulse per matched table entry
//   match_idx  : index of the entry just matched, valid with match_stb
//   done       : run finished; held until the next start or reset
//   pass/fail/timeout : run result, valid while done
module checkbits_seq_monitor #(
    parameter int          N_ENTRIES      = 16,
    parameter int          STABLE_CYCLES  = 4,
    parameter int          TIMEOUT_CYCLES = 250000,
    parameter logic [15:0] START_MARK     = 16'hAB40,
    parameter logic [15:0] END_MARK       = 16'hAB51,
    parameter bit          STRICT         = 1'b1,
    localparam int         AW             = $clog2(N_ENTRIES)
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic [15:0]   checkbits,
    input  logic          exp_we,
    input  logic [AW-1:0] exp_addr,
    input  logic [15:0]   exp_data,
    input  logic [AW:0]   exp_count,
    input  logic          start,
    output logic          busy,
    output logic          match_stb,
    output logic [AW-1:0] match_idx,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_TRACK,
        ST_WAIT_END,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]    cb_q;
    logic [SCW-1:0] stab_cnt;
    logic           settle_stb;

    logic [15:0]    exp_tbl [N_ENTRIES];
    logic [AW-1:0]  idx;
    logic [AW:0]    cnt_lat;
    logic [TW-1:0]  timer;
    logic           pass_q, fail_q, to_q;

    logic           start_ok, busy_st, timer_hit;
    logic           hit_cur, prev_hit;
    logic           ev_match, ev_pass, ev_fail, ev_to;

    // Stability counter stops at STABLE_CYCLES so the settle strobe fires once.
    function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] c);
        return (c == SCW'(STABLE_CYCLES)) ? c : c + SCW'(1);
    endfunction

    // Entry count cannot exceed the table depth.
    function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
        return (c > (AW+1)'(N_ENTRIES)) ? (AW+1)'(N_ENTRIES) : c;
    endfunction

    // ---- settle filter stage ----
    always_ff @(posedge clock) begin
        if (!resetb) begin
            cb_q     <= '0;
            stab_cnt <= '0;
        end else if (checkbits != cb_q) begin
            cb_q     <= checkbits;
            stab_cnt <= '0;
        end else begin
            stab_cnt <= sat_inc(stab_cnt);
        end
    end

    assign settle_stb = (checkbits == cb_q) && (stab_cnt == SCW'(STABLE_CYCLES - 1));

    // Expected table: no reset, so a run can be repeated without reloading.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && exp_we)
            exp_tbl[exp_addr] <= exp_data;
    end

    // ---- sequence tracking stage ----
    assign busy_st   = (state == ST_ARM) || (state == ST_TRACK) || (state == ST_WAIT_END);
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign timer_hit = busy_st && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign hit_cur   = (state == ST_TRACK) && settle_stb && (cb_q == exp_tbl[idx]);

    // A value already matched earlier in the run may linger or reappear; it is
    // not treated as a sequence error.
    always_comb begin
        prev_hit = 1'b0;
        for (int j = 0; j < N_ENTRIES; j++) begin
            if (((AW+1)'(j) < {1'b0, idx}) && (exp_tbl[j] == cb_q))
                prev_hit = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ev_match  = 1'b0;
        ev_pass   = 1'b0;
        ev_fail   = 1'b0;
        ev_to     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok)
                    state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (settle_stb && cb_q == START_MARK)
                    state_nxt = (cnt_lat == '0) ? ST_WAIT_END : ST_TRACK;
            end
            ST_TRACK: begin
                if (hit_cur) begin
                    ev_match = 1'b1;
                    if (({1'b0, idx} + (AW+1)'(1)) == cnt_lat)
                        state_nxt = ST_WAIT_END;
                end else if (settle_stb && cb_q != START_MARK && !prev_hit && STRICT) begin
                    ev_fail   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT_END: begin
                if (settle_stb && cb_q == END_MARK) begin
                    ev_pass   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A deciding settle in the same cycle takes precedence over the timeout.
        if (timer_hit && !ev_pass && !ev_fail) begin
            ev_to     = 1'b1;
            state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            idx     <= '0;
            cnt_lat <= '0;
            timer   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else if (start_ok) begin
            idx     <= '0;
            cnt_lat <= clamp_count(exp_count);
            timer   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            if (busy_st)
                timer <= timer + TW'(1);
            if (ev_match)
                idx <= idx + AW'(1);
            if (ev_pass)
                pass_q <= 1'b1;
            if (ev_fail || ev_to)
                fail_q <= 1'b1;
            if (ev_to)
                to_q <= 1'b1;
        end
    end

    // ---- output stage ----
    always_comb begin
        busy      = busy_st;
        done      = (state == ST_DONE);
        match_stb = hit_cur;
        match_idx = idx;
        pass      = pass_q;
        fail      = fail_q;
        timeout   = to_q;
    end

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
module tb_checkbits_seq_monitor;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          resetb;
    logic [15:0]   checkbits;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_data;
    logic [AW:0]   exp_count;
    logic          start;
    logic          busy, match_stb, done, pass, fail, timeout;
    logic [AW-1:0] match_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mtot   = 0;
    logic [AW-1:0] mlog [256];

    logic [15:0] tbl [11] = '{16'h0000, 16'hFFF6, 16'hFFE3, 16'hFFE7, 16'h0023,
                              16'h009E, 16'h0151, 16'h021B, 16'h02DC, 16'h0393, 16'h044A};

    checkbits_seq_monitor #(
        .N_ENTRIES(16),
        .STABLE_CYCLES(4),
        .TIMEOUT_CYCLES(1000),
        .START_MARK(16'hAB40),
        .END_MARK(16'hAB51),
        .STRICT(1'b1)
    ) dut (
        .clock(clock),
        .resetb(resetb),
        .checkbits(checkbits),
        .exp_we(exp_we),
        .exp_addr(exp_addr),
        .exp_data(exp_data),
        .exp_count(exp_count),
        .start(start),
        .busy(busy),
        .match_stb(match_stb),
        .match_idx(match_idx),
        .done(done),
        .pass(pass),
        .fail(fail),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (match_stb) begin
            mlog[mtot[7:0]] <= match_idx;
            mtot <= mtot + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        checkbits = v;
        step(n);
    endtask

    task automatic drive_tbl(input int from, input int to);
        for (int i = from; i <= to; i++) hold(tbl[i], 10);
    endtask

    task automatic start_run(input logic [AW:0] cnt, output int base, output int t0);
        checkbits = 16'h5555;
        step(6);
        exp_count = cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        base = mtot;
        t0   = cyc;
    endtask

    task automatic check_result(input string tag, input bit ep, input bit ef, input bit et,
                                input int em, input int base);
        step(2);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, ep);
        chk({tag, "_fail"}, fail, ef);
        chk({tag, "_timeout"}, timeout, et);
        chk({tag, "_nmatch"}, mtot - base, em);
        for (int k = 0; k < em; k++) chk({tag, "_idx"}, mlog[base + k], k);
    endtask

    initial begin
        int base, t0, n;
        resetb = 1'b0; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        exp_count = '0; checkbits = '0;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_mstb", match_stb, 0);
        chk("rst_midx", match_idx, 0);
        resetb = 1'b1;
        step(1);

        for (int i = 0; i < 11; i++) begin
            exp_we = 1'b1; exp_addr = AW'(i); exp_data = tbl[i];
            step(1);
        end
        exp_we = 1'b0;

        // full sequence, with a stray start while busy
        start_run(5'd11, base, t0);
        chk("t1_busy", busy, 1);
        hold(16'hAB40, 10);
        hold(tbl[0], 10);
        start = 1'b1; step(1); start = 1'b0;
        drive_tbl(1, 10);
        hold(16'hAB51, 10);
        check_result("t1", 1, 0, 0, 11, base);

        // strict mismatch, plus a table write attempt while busy
        start_run(5'd11, base, t0);
        exp_we = 1'b1; exp_addr = 4'd2; exp_data = 16'h1234;
        step(1);
        exp_we = 1'b0;
        hold(16'hAB40, 10);
        drive_tbl(0, 1);
        checkbits = 16'h1234;
        step(4);
        chk("t2_done_early", done, 0);
        step(1);
        chk("t2_done_lat", done, 1);
        chk("t2_fail_lat", fail, 1);
        hold(16'h1234, 5);
        check_result("t2", 0, 1, 0, 2, base);

        // short glitch between entries must not settle
        start_run(5'd11, base, t0);
        hold(16'hAB40, 10);
        drive_tbl(0, 1);
        hold(16'h1234, 2);
        drive_tbl(2, 10);
        hold(16'hAB51, 10);
        check_result("t3", 1, 0, 0, 11, base);

        // timeout at 1000 cycles after the accepting edge
        start_run(5'd11, base, t0);
        hold(16'hAB40, 10);
        checkbits = 16'h0000;
        while (!done && (cyc - t0) < 1100) step(1);
        chk("t4_to_cycle", cyc - t0, 1000);
        check_result("t4", 0, 1, 1, 1, base);

        // empty table: start mark then end mark passes
        start_run(5'd0, base, t0);
        hold(16'hAB40, 10);
        hold(16'hAB51, 10);
        check_result("t5", 1, 0, 0, 0, base);

        // reset one cycle after the 5th match, then rerun on the kept table
        start_run(5'd11, base, t0);
        hold(16'hAB40, 10);
        drive_tbl(0, 3);
        checkbits = tbl[4];
        n = 0;
        while (!match_stb && n < 20) begin
            step(1);
            n++;
        end
        chk("t6_m5_seen", match_stb, 1);
        chk("t6_m5_idx", match_idx, 4);
        step(1);
        resetb = 1'b0;
        step(1);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_pass", pass, 0);
        chk("t6_fail", fail, 0);
        chk("t6_timeout", timeout, 0);
        chk("t6_mstb", match_stb, 0);
        chk("t6_midx", match_idx, 0);
        resetb = 1'b1;
        step(1);
        start_run(5'd11, base, t0);
        hold(16'hAB40, 10);
        drive_tbl(0, 10);
        hold(16'hAB51, 10);
        check_result("t6r", 1, 0, 0, 11, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/checkbits_seq_monitor.md
CHECKBITS_SEQ_MONITOR -- requirements
Module: checkbits_seq_monitor

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 16, expected-value table depth (power of 2, 2..64).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, consecutive cycles a checkbits value must hold to count as settled (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000, cycles allowed from start to completion.
REQ-004 SHALL have parameter START_MARK, default 16'hAB40, and END_MARK, default 16'hAB51, the sequence delimiters.
REQ-005 SHALL have parameter STRICT, default 1; when 1, an unexpected settled value fails the run.
REQ-006 clock  input  1  single clock; all logic on rising edge.
REQ-007 resetb  input  1  synchronous, active-low reset.
REQ-008 checkbits  input  16  observed status word (mprj_io[31:16]).
REQ-009 exp_we  input  1  table write strobe.
REQ-010 exp_addr  input  log2(N_ENTRIES)  table write address.
REQ-011 exp_data  input  16  table write data.
REQ-012 exp_count  input  log2(N_ENTRIES)+1  number of valid table entries, sampled at start.
REQ-013 start  input  1  one-cycle pulse to arm the monitor.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 match_stb  output  1  one-cycle pulse per matched expected entry.
REQ-016 match_idx  output  log2(N_ENTRIES)  index of the entry just matched, valid with match_stb.
REQ-017 done  output  1  high once the run ends; holds until next start or reset.
REQ-018 pass, fail, timeout  output  1 each  run result flags, valid while done.

Function
REQ-019 Settle filter SHALL register cb_q; if checkbits != cb_q then cb_q<=checkbits and stab_cnt<=0, else stab_cnt increments saturating at STABLE_CYCLES.
REQ-020 settle_stb SHALL pulse exactly one cycle, the cycle stab_cnt==STABLE_CYCLES-1 and checkbits==cb_q; value cb_q is the settled value; glitches shorter than STABLE_CYCLES SHALL never settle.
REQ-021 FSM states SHALL be IDLE, ARM, TRACK, WAIT_END, DONE.
REQ-022 IDLE: exp_we writes exp_data to table[exp_addr] next cycle; exp_we outside IDLE SHALL be ignored.
REQ-023 IDLE + start: latch min(exp_count, N_ENTRIES) as cnt_lat, clear idx, flags, timer; go ARM; busy=1 next cycle.
REQ-024 start while busy SHALL be ignored.
REQ-025 ARM: settled START_MARK -> TRACK (cnt_lat>0) or WAIT_END (cnt_lat==0); other settled values ignored.
REQ-026 TRACK: settled value == table[idx] -> match_stb=1, match_idx=idx, idx+1; after last entry -> WAIT_END.
REQ-027 TRACK: settled value equal to START_MARK or previously matched value SHALL be ignored; any other mismatch -> DONE with fail=1 if STRICT, else ignored.
REQ-028 WAIT_END: settled END_MARK -> DONE, pass=1; other settled values ignored.
REQ-029 Timer SHALL count every cycle while busy; reaching TIMEOUT_CYCLES in a non-DONE state -> DONE, fail=1, timeout=1.
REQ-030 If timeout and a completing event coincide in one cycle, the completing event SHALL win (pass=1, timeout=0).
REQ-031 DONE: busy=0, done=1, flags held; start -> re-arm per REQ-023 (table contents retained).
REQ-032 Exactly one of pass/fail SHALL be 1 while done; both 0 while not done.
REQ-033 match_stb-to-settle latency SHALL be 0 (same cycle as settle_stb); flag update latency 1 cycle after the deciding settle_stb.

Reset
REQ-034 resetb=0 at a rising edge SHALL force IDLE, busy=0, done=0, pass=0, fail=0, timeout=0, match_stb=0, match_idx=0, cb_q=0, stab_cnt=0, timer=0.
REQ-035 Table contents SHALL be unaffected by reset; reset mid-run SHALL abort without asserting any result flag.

Verification
REQ-036 Load 11 entries 0000,FFF6,FFE3,FFE7,0023,009E,0151,021B,02DC,0393,044A; start; drive AB40, the 11 values, AB51, each held 10 cycles -> 11 match_stb with idx 0..10, then done=1, pass=1.
REQ-037 Same table, STRICT=1; drive AB40,0000,FFF6,1234 (held 10 cycles) -> fail=1 after 1234 settles, timeout=0, match count 2.
REQ-038 Same run with a 2-cycle 1234 glitch between FFF6 and FFE3 -> glitch ignored, pass=1.
REQ-039 TIMEOUT_CYCLES=1000; drive AB40 then hold 0000 -> done=1, fail=1, timeout=1 at cycle 1000 after start.
REQ-040 exp_count=0; drive AB40 then AB51 -> pass=1, no match_stb.
REQ-041 Assert resetb=0 one cycle after 5th match_stb -> all outputs 0 next cycle; restart with same table -> table reused, pass=1.
